// File: rtl/rd_buf_req_arbiter.sv
// rd_buf_req_arbiter
// Shares one read-circular-buffer tile between NUM_SRCS requester engines.
// Arbitration is round-robin. Only one read is outstanding at a time, and the
// grant is held from request acceptance until the last data beat is accepted,
// so each requester sees a contiguous, unmixed data stream.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module rd_buf_req_arbiter #(
   parameter int NUM_SRCS  = 2,
   parameter int BUF_PTR_W = 16,
   parameter int SRC_IDX_W = $clog2(NUM_SRCS)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   // requester side: requests
   input  logic [NUM_SRCS-1:0]                      src_arb_req_val,
   input  logic [NUM_SRCS*`FLOW_ID_W-1:0]           src_arb_req_flowid,
   input  logic [NUM_SRCS*BUF_PTR_W-1:0]            src_arb_req_offset,
   input  logic [NUM_SRCS*`MSG_DATA_SIZE_WIDTH-1:0] src_arb_req_size,
   output logic [NUM_SRCS-1:0]                      arb_src_req_rdy,
   // requester side: data
   output logic [NUM_SRCS-1:0]                      arb_src_data_val,
   output logic [`MAC_INTERFACE_W-1:0]              arb_src_data,
   output logic                                     arb_src_data_last,
   output logic [`MAC_PADBYTES_W-1:0]               arb_src_data_padbytes,
   input  logic [NUM_SRCS-1:0]                      src_arb_data_rdy,
   // buffer tile side: request
   output logic                                     arb_rd_buf_req_val,
   output logic [`FLOW_ID_W-1:0]                    arb_rd_buf_req_flowid,
   output logic [BUF_PTR_W-1:0]                     arb_rd_buf_req_offset,
   output logic [`MSG_DATA_SIZE_WIDTH-1:0]          arb_rd_buf_req_size,
   input  logic                                     rd_buf_arb_req_rdy,
   // buffer tile side: data
   input  logic                                     rd_buf_arb_data_val,
   input  logic [`MAC_INTERFACE_W-1:0]              rd_buf_arb_data,
   input  logic                                     rd_buf_arb_data_last,
   input  logic [`MAC_PADBYTES_W-1:0]               rd_buf_arb_data_padbytes,
   output logic                                     arb_rd_buf_data_rdy,
   // status
   output logic                                     arb_busy,
   output logic [SRC_IDX_W-1:0]                     arb_grant_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   state_e                          state_q, state_d;
   logic [SRC_IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [SRC_IDX_W-1:0]            grant_q, grant_d;
   logic [`FLOW_ID_W-1:0]           flowid_q, flowid_d;
   logic [BUF_PTR_W-1:0]            offset_q, offset_d;
   logic [`MSG_DATA_SIZE_WIDTH-1:0] size_q, size_d;

   logic                            pick_val_s;
   logic [SRC_IDX_W-1:0]            pick_idx_s;
   logic [`MSG_DATA_SIZE_WIDTH-1:0] pick_size_s;

   // (base + k) mod NUM_SRCS; keeps requester indices inside 0..NUM_SRCS-1
   // even when NUM_SRCS is not a power of two.
   function automatic logic [SRC_IDX_W-1:0] rr_wrap(input logic [SRC_IDX_W-1:0] base,
                                                    input int k);
      int sum_v;
      sum_v = int'(base) + k;
      return SRC_IDX_W'(sum_v % NUM_SRCS);
   endfunction

   // Round-robin search: first valid requester starting at rr_ptr_q.
   always_comb begin
      pick_val_s = 1'b0;
      pick_idx_s = '0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         if (!pick_val_s && src_arb_req_val[rr_wrap(rr_ptr_q, k)]) begin
            pick_val_s = 1'b1;
            pick_idx_s = rr_wrap(rr_ptr_q, k);
         end else begin
            pick_val_s = pick_val_s;
         end
      end
   end

   assign pick_size_s = src_arb_req_size[pick_idx_s*`MSG_DATA_SIZE_WIDTH +: `MSG_DATA_SIZE_WIDTH];

   // Next-state and handshake logic for the IDLE/REQ/DATA arbiter FSM.
   always_comb begin
      state_d             = state_q;
      rr_ptr_d            = rr_ptr_q;
      grant_d             = grant_q;
      flowid_d            = flowid_q;
      offset_d            = offset_q;
      size_d              = size_q;
      arb_src_req_rdy     = '0;
      arb_src_data_val    = '0;
      arb_rd_buf_req_val  = 1'b0;
      arb_rd_buf_data_rdy = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_val_s) begin
               arb_src_req_rdy[pick_idx_s] = 1'b1;
               grant_d  = pick_idx_s;
               flowid_d = src_arb_req_flowid[pick_idx_s*`FLOW_ID_W +: `FLOW_ID_W];
               offset_d = src_arb_req_offset[pick_idx_s*BUF_PTR_W +: BUF_PTR_W];
               size_d   = pick_size_s;
               if (pick_size_s != '0) begin
                  state_d = ST_REQ;
               end else begin
                  // Empty read: consume it locally, never bother the tile.
                  rr_ptr_d = rr_wrap(pick_idx_s, 1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            arb_rd_buf_req_val = 1'b1;
            if (rd_buf_arb_req_rdy) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DATA: begin
            arb_src_data_val[grant_q] = rd_buf_arb_data_val;
            arb_rd_buf_data_rdy       = src_arb_data_rdy[grant_q];
            if (rd_buf_arb_data_val && src_arb_data_rdy[grant_q] && rd_buf_arb_data_last) begin
               state_d  = ST_IDLE;
               rr_ptr_d = rr_wrap(grant_q, 1);
            end else begin
               state_d = ST_DATA;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, round-robin pointer, grant and latched request fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         flowid_q <= '0;
         offset_q <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         flowid_q <= flowid_d;
         offset_q <= offset_d;
         size_q   <= size_d;
      end
   end

   // Shared data bus is a plain passthrough; only the valid is steered.
   assign arb_src_data          = rd_buf_arb_data;
   assign arb_src_data_last     = rd_buf_arb_data_last;
   assign arb_src_data_padbytes = rd_buf_arb_data_padbytes;

   assign arb_rd_buf_req_flowid = flowid_q;
   assign arb_rd_buf_req_offset = offset_q;
   assign arb_rd_buf_req_size   = size_q;

   assign arb_busy      = (state_q != ST_IDLE);
   assign arb_grant_idx = grant_q;

endmodule

// File: tb/tb_rd_buf_req_arbiter.sv
// tb_rd_buf_req_arbiter
// Directed bench for the four-requester configuration of rd_buf_req_arbiter.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module tb_rd_buf_req_arbiter;

   localparam int NS  = 4;
   localparam int PW  = 16;
   localparam int IW  = 2;
   localparam int FW  = `FLOW_ID_W;
   localparam int SW  = `MSG_DATA_SIZE_WIDTH;
   localparam int DW  = `MAC_INTERFACE_W;
   localparam int PBW = `MAC_PADBYTES_W;

   logic              clk;
   logic              rst;
   logic [NS-1:0]     req_val;
   logic [NS*FW-1:0]  req_flowid;
   logic [NS*PW-1:0]  req_offset;
   logic [NS*SW-1:0]  req_size;
   logic [NS-1:0]     req_rdy;
   logic [NS-1:0]     dat_val;
   logic [DW-1:0]     dat;
   logic              dat_last;
   logic [PBW-1:0]    dat_pad;
   logic [NS-1:0]     src_dat_rdy;
   logic              rb_req_val;
   logic [FW-1:0]     rb_req_flowid;
   logic [PW-1:0]     rb_req_offset;
   logic [SW-1:0]     rb_req_size;
   logic              rb_req_rdy;
   logic              rb_dat_val;
   logic [DW-1:0]     rb_dat;
   logic              rb_dat_last;
   logic [PBW-1:0]    rb_dat_pad;
   logic              rb_dat_rdy;
   logic              busy;
   logic [IW-1:0]     grant_idx;

   int chk_cnt = 0;
   int err_cnt = 0;

   rd_buf_req_arbiter #(.NUM_SRCS(NS), .BUF_PTR_W(PW)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .src_arb_req_val          (req_val),
      .src_arb_req_flowid       (req_flowid),
      .src_arb_req_offset       (req_offset),
      .src_arb_req_size         (req_size),
      .arb_src_req_rdy          (req_rdy),
      .arb_src_data_val         (dat_val),
      .arb_src_data             (dat),
      .arb_src_data_last        (dat_last),
      .arb_src_data_padbytes    (dat_pad),
      .src_arb_data_rdy         (src_dat_rdy),
      .arb_rd_buf_req_val       (rb_req_val),
      .arb_rd_buf_req_flowid    (rb_req_flowid),
      .arb_rd_buf_req_offset    (rb_req_offset),
      .arb_rd_buf_req_size      (rb_req_size),
      .rd_buf_arb_req_rdy       (rb_req_rdy),
      .rd_buf_arb_data_val      (rb_dat_val),
      .rd_buf_arb_data          (rb_dat),
      .rd_buf_arb_data_last     (rb_dat_last),
      .rd_buf_arb_data_padbytes (rb_dat_pad),
      .arb_rd_buf_data_rdy      (rb_dat_rdy),
      .arb_busy                 (busy),
      .arb_grant_idx            (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [FW-1:0] flow,
                          input logic [PW-1:0] off, input logic [SW-1:0] size);
      req_flowid[i*FW +: FW] = flow;
      req_offset[i*PW +: PW] = off;
      req_size[i*SW +: SW]   = size;
      req_val[i]             = 1'b1;
   endtask

   function automatic logic [DW-1:0] beat_pat(input int src, input int b);
      logic [31:0] w;
      w = 32'hB0DA_0000 + 32'(src * 256 + b);
      return {(DW/32){w}};
   endfunction

   // Full read of 'beats' beats for requester src, expected to win arbitration now.
   task automatic run_read(input int src, input int beats, input logic [FW-1:0] e_flow,
                           input logic [PW-1:0] e_off, input logic [SW-1:0] e_size);
      logic [NS-1:0] onehot;
      onehot = 4'b0001 << src;
      #1;
      check_val("grant_rdy", DW'(req_rdy), DW'(onehot));
      next_cyc();
      check_val("req_val", DW'(rb_req_val), DW'(1'b1));
      check_val("req_flowid", DW'(rb_req_flowid), DW'(e_flow));
      check_val("req_offset", DW'(rb_req_offset), DW'(e_off));
      check_val("req_size", DW'(rb_req_size), DW'(e_size));
      check_val("grant_idx", DW'(grant_idx), DW'(src));
      check_val("rdy_blocked_req", DW'(req_rdy), DW'(4'b0000));
      rb_req_rdy = 1'b1;
      next_cyc();
      rb_req_rdy = 1'b0;
      for (int b = 0; b < beats; b++) begin
         rb_dat_val  = 1'b1;
         rb_dat      = beat_pat(src, b);
         rb_dat_last = (b == beats - 1);
         rb_dat_pad  = (b == beats - 1) ? 6'd5 : 6'd0;
         #1;
         check_val("data_val", DW'(dat_val), DW'(onehot));
         check_val("data", dat, beat_pat(src, b));
         check_val("data_rdy", DW'(rb_dat_rdy), DW'(1'b1));
         next_cyc();
      end
      rb_dat_val  = 1'b0;
      rb_dat_last = 1'b0;
      rb_dat_pad  = 6'd0;
      #1;
      check_val("busy_done", DW'(busy), DW'(1'b0));
      check_val("grant_hold", DW'(grant_idx), DW'(src));
   endtask

   initial begin
      rst         = 1'b1;
      req_val     = '0;
      req_flowid  = '0;
      req_offset  = '0;
      req_size    = '0;
      src_dat_rdy = 4'hF;
      rb_req_rdy  = 1'b0;
      rb_dat_val  = 1'b0;
      rb_dat      = '0;
      rb_dat_last = 1'b0;
      rb_dat_pad  = 6'd0;
      next_cyc();
      next_cyc();
      check_val("rst_busy", DW'(busy), DW'(1'b0));
      check_val("rst_grant", DW'(grant_idx), DW'(2'd0));
      check_val("rst_req_val", DW'(rb_req_val), DW'(1'b0));
      check_val("rst_data_rdy", DW'(rb_dat_rdy), DW'(1'b0));
      check_val("rst_data_val", DW'(dat_val), DW'(4'b0000));
      rst = 1'b0;
      next_cyc();

      // Single request from src1, 2 beats of 64 bytes.
      set_req(1, 8'h11, 16'h0040, 16'd128);
      #1;
      check_val("single_busy_idle", DW'(busy), DW'(1'b0));
      next_cyc();
      req_val = '0;
      check_val("single_req_val", DW'(rb_req_val), DW'(1'b1));
      check_val("single_offset", DW'(rb_req_offset), DW'(16'h0040));
      check_val("single_size", DW'(rb_req_size), DW'(16'd128));
      check_val("single_busy", DW'(busy), DW'(1'b1));
      rb_req_rdy = 1'b1;
      next_cyc();
      rb_req_rdy = 1'b0;
      for (int b = 0; b < 2; b++) begin
         rb_dat_val  = 1'b1;
         rb_dat      = beat_pat(1, b);
         rb_dat_last = (b == 1);
         #1;
         check_val("single_dval", DW'(dat_val), DW'(4'b0010));
         check_val("single_last", DW'(dat_last), DW'(b == 1));
         next_cyc();
      end
      rb_dat_last = 1'b0;
      #1;
      // Stray downstream valid in IDLE must be back-pressured, not routed.
      check_val("stray_idle_rdy", DW'(rb_dat_rdy), DW'(1'b0));
      check_val("stray_idle_val", DW'(dat_val), DW'(4'b0000));
      check_val("single_grant", DW'(grant_idx), DW'(2'd1));
      check_val("single_idle", DW'(busy), DW'(1'b0));
      rb_dat_val = 1'b0;

      // Fairness: all four requesting continuously, from a fresh reset.
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      for (int i = 0; i < NS; i++) set_req(i, 8'(8'h20 + i), 16'(i * 256), 16'd64);
      for (int n = 0; n < 6; n++) begin
         run_read(n % NS, 1, 8'(8'h20 + (n % NS)), 16'((n % NS) * 256), 16'd64);
      end
      req_val = '0;

      // Zero-size request: consumed locally, next grant starts at src1.
      set_req(0, 8'h30, 16'h0100, 16'd0);
      #1;
      check_val("zero_rdy", DW'(req_rdy), DW'(4'b0001));
      next_cyc();
      req_val = '0;
      #1;
      check_val("zero_req_val", DW'(rb_req_val), DW'(1'b0));
      check_val("zero_busy", DW'(busy), DW'(1'b0));
      set_req(0, 8'h31, 16'h0200, 16'd64);
      set_req(1, 8'h41, 16'h0300, 16'd64);
      run_read(1, 1, 8'h41, 16'h0300, 16'd64);
      req_val = '0;

      // Backpressure: src0 3 beats, stalls 5 cycles after beat 1; src1 waiting.
      set_req(0, 8'h50, 16'h0400, 16'd192);
      set_req(1, 8'h51, 16'h0500, 16'd64);
      #1;
      check_val("bp_rdy", DW'(req_rdy), DW'(4'b0001));
      next_cyc();
      req_val[0] = 1'b0;
      rb_req_rdy = 1'b1;
      next_cyc();
      rb_req_rdy  = 1'b0;
      rb_dat_val  = 1'b1;
      rb_dat      = beat_pat(0, 0);
      #1;
      check_val("bp_beat1_rdy", DW'(rb_dat_rdy), DW'(1'b1));
      next_cyc();
      src_dat_rdy = 4'b1110;
      rb_dat      = beat_pat(0, 1);
      for (int c = 0; c < 5; c++) begin
         #1;
         check_val("bp_stall_rdy", DW'(rb_dat_rdy), DW'(1'b0));
         check_val("bp_stall_val", DW'(dat_val), DW'(4'b0001));
         check_val("bp_src1_blocked", DW'(req_rdy), DW'(4'b0000));
         next_cyc();
      end
      src_dat_rdy = 4'hF;
      #1;
      check_val("bp_beat2_data", dat, beat_pat(0, 1));
      next_cyc();
      rb_dat      = beat_pat(0, 2);
      rb_dat_last = 1'b1;
      #1;
      check_val("bp_last_no_grant", DW'(req_rdy), DW'(4'b0000));
      check_val("bp_beat3_data", dat, beat_pat(0, 2));
      next_cyc();
      rb_dat_val  = 1'b0;
      rb_dat_last = 1'b0;
      run_read(1, 1, 8'h51, 16'h0500, 16'd64);
      req_val = '0;

      // Downstream stall for 4 cycles in REQ, with a stray data valid present.
      set_req(2, 8'h62, 16'h0600, 16'd64);
      #1;
      check_val("stall_rdy", DW'(req_rdy), DW'(4'b0100));
      next_cyc();
      req_val    = '0;
      rb_dat_val = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_val("stall_req_val", DW'(rb_req_val), DW'(1'b1));
         check_val("stall_offset", DW'(rb_req_offset), DW'(16'h0600));
         check_val("stall_size", DW'(rb_req_size), DW'(16'd64));
         check_val("stall_no_data", DW'(rb_dat_rdy), DW'(1'b0));
         next_cyc();
      end
      rb_dat_val = 1'b0;
      rb_req_rdy = 1'b1;
      next_cyc();
      rb_req_rdy  = 1'b0;
      rb_dat_val  = 1'b1;
      rb_dat_last = 1'b1;
      #1;
      check_val("stall_data_val", DW'(dat_val), DW'(4'b0100));
      next_cyc();
      rb_dat_val  = 1'b0;
      rb_dat_last = 1'b0;

      // Reset mid-DATA after beat 1 of 4.
      set_req(3, 8'h73, 16'h0700, 16'd256);
      #1;
      check_val("rstd_rdy", DW'(req_rdy), DW'(4'b1000));
      next_cyc();
      req_val    = '0;
      rb_req_rdy = 1'b1;
      next_cyc();
      rb_req_rdy = 1'b0;
      rb_dat_val = 1'b1;
      rb_dat     = beat_pat(3, 0);
      next_cyc();
      rb_dat = beat_pat(3, 1);
      rst    = 1'b1;
      next_cyc();
      rst = 1'b0;
      #1;
      check_val("rstd_busy", DW'(busy), DW'(1'b0));
      check_val("rstd_grant", DW'(grant_idx), DW'(2'd0));
      check_val("rstd_req_val", DW'(rb_req_val), DW'(1'b0));
      check_val("rstd_data_rdy", DW'(rb_dat_rdy), DW'(1'b0));
      check_val("rstd_data_val", DW'(dat_val), DW'(4'b0000));
      rb_dat_val = 1'b0;
      // rr pointer back at 0: src2 must beat src3.
      set_req(2, 8'h82, 16'h0800, 16'd64);
      set_req(3, 8'h83, 16'h0900, 16'd64);
      run_read(2, 1, 8'h82, 16'h0800, 16'd64);
      req_val = '0;
      set_req(0, 8'h90, 16'h0A00, 16'd128);
      run_read(0, 2, 8'h90, 16'h0A00, 16'd128);
      req_val = '0;

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
